// File: rtl/count_reader_pkg.sv
// rtl/count_reader_pkg.sv - shared types and frame geometry for the counter reader
package count_reader_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int CNT_W_DEF  = 64;
  localparam int BYTE_W_DEF = 8;
  localparam logic [7:0] HDR_DEF = 8'hA5;

  // Header + both counters split into symbols + trailing checksum
  function automatic int frame_bytes(input int cnt_w, input int byte_w);
    return (2 * cnt_w) / byte_w + 2;
  endfunction

endpackage

// File: rtl/count_reader.sv
// rtl/count_reader.sv - snapshots two event counters and streams them as a checksummed byte frame
module count_reader
  import count_reader_pkg::*;
#(
  parameter int                CNT_W  = CNT_W_DEF,
  parameter int                BYTE_W = BYTE_W_DEF,
  parameter logic [BYTE_W-1:0] HDR    = HDR_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req,
  input  logic [CNT_W-1:0]  Cnt0,
  input  logic [CNT_W-1:0]  Cnt1,
  output logic [BYTE_W-1:0] TxData,
  output logic              TxValid,
  input  logic              TxReady,
  output logic              Busy,
  output logic              Done,
  output logic              Overrun
);

  localparam int NB    = frame_bytes(CNT_W, BYTE_W);
  localparam int IDX_W = $clog2(NB);
  localparam logic [IDX_W-1:0] LAST     = IDX_W'(NB - 1);
  localparam logic [IDX_W-1:0] CHK_PREV = IDX_W'(NB - 2);

  generate
    if ((CNT_W % BYTE_W) != 0) begin : g_bad_width
      $error("count_reader: CNT_W must be a multiple of BYTE_W");
    end
  endgenerate

  state_t              state;
  logic [2*CNT_W-1:0]  snap;
  logic [IDX_W-1:0]    idx;
  logic [BYTE_W-1:0]   chk;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      snap    <= '0;
      idx     <= '0;
      chk     <= '0;
      TxData  <= '0;
      TxValid <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Req) begin
            snap    <= {Cnt1, Cnt0};
            idx     <= '0;
            chk     <= '0;
            TxData  <= HDR;
            TxValid <= 1'b1;
            Busy    <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (Req) Overrun <= 1'b1;
          if (TxReady) begin
            if (idx == LAST) begin
              state   <= IDLE;
              idx     <= '0;
              TxData  <= '0;
              TxValid <= 1'b0;
              Busy    <= 1'b0;
              Done    <= 1'b1;
            end else begin
              idx  <= idx + IDX_W'(1);
              snap <= snap >> BYTE_W;
              // chk already holds every data byte once the last one is on the wire
              if (idx == CHK_PREV) begin
                TxData <= chk;
              end else begin
                TxData <= snap[BYTE_W-1:0];
                chk    <= chk ^ snap[BYTE_W-1:0];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_reader.sv
// tb/tb_count_reader.sv - scoreboard bench for count_reader
module tb_count_reader;

  localparam int NB = 18;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req = 1'b0;
  logic [63:0] Cnt0 = '0;
  logic [63:0] Cnt1 = '0;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady = 1'b0;
  logic        Busy;
  logic        Done;
  logic        Overrun;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  int  frame_pos   = 0;
  bit  expect_done = 0;
  bit  prev_stall  = 0;
  logic [7:0] prev_data = '0;
  int  ready_pct = 100;
  bit  scramble  = 0;

  count_reader dut (
    .Clk(clk), .Reset(Reset), .Req(Req), .Cnt0(Cnt0), .Cnt1(Cnt1),
    .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
    .Busy(Busy), .Done(Done), .Overrun(Overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2 TxReady = ($urandom_range(99) < ready_pct);
  end

  always @(posedge clk) begin
    #3 if (scramble) begin
      Cnt0 = {$urandom, $urandom};
      Cnt1 = {$urandom, $urandom};
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference frame: header, counter bytes least significant first, XOR of the data bytes
  task automatic push_frame(input logic [63:0] c0, input logic [63:0] c1);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 16; i++) begin
      b = (i < 8) ? 8'((c0 >> (8 * i)) & 64'hFF) : 8'((c1 >> (8 * (i - 8))) & 64'hFF);
      exp_q.push_back(b);
      x = x ^ b;
    end
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (Reset) begin
      frame_pos   = 0;
      expect_done = 0;
      prev_stall  = 0;
    end else begin
      check("done_pulse", Done, expect_done);
      check("busy_vs_valid", Busy, TxValid);
      expect_done = 0;
      if (prev_stall) check("stall_hold", {TxValid, TxData}, {1'b1, prev_data});
      if (frame_pos > 0) check("valid_mid_frame", TxValid, 1'b1);
      if (!TxValid) check("idle_data_zero", TxData, 8'h00);
      prev_stall = TxValid && !TxReady;
      prev_data  = TxData;
      if (TxValid && TxReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", TxData, 8'hxx);
        end else begin
          check("frame_byte", TxData, exp_q.pop_front());
        end
        frame_pos++;
        if (frame_pos == NB) begin
          frame_pos   = 0;
          expect_done = 1;
        end
      end
    end
  end

  task automatic start_frame(input logic [63:0] c0, input logic [63:0] c1, input bit scr);
    @(posedge clk); #1;
    scramble = 0;
    Cnt0 = c0;
    Cnt1 = c1;
    Req  = 1'b1;
    push_frame(c0, c1);
    @(posedge clk); #1;
    Req = 1'b0;
    scramble = scr;
    @(negedge clk);
    check("first_byte_latency", {TxValid, Busy}, 2'b11);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || TxValid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    scramble = 0;
    check("idle_timeout", t < 3000, 1'b1);
  endtask

  task automatic wait_pos(input int p);
    int t;
    t = 0;
    while (frame_pos < p && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("pos_timeout", t < 1000, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    Reset = 1'b1;
    Req   = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    Reset = 1'b0;
    @(negedge clk);
    check("reset_state", {TxValid, Busy, Done, Overrun, TxData}, 12'h000);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    do_reset();

    // Basic frame, full throughput: Done appears 19 negedges after the capture edge
    ready_pct = 100;
    repeat (2) @(posedge clk);
    start_frame(64'h0123_4567_89AB_CDEF, 64'h1, 0);
    n = 1;
    while (!Done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("basic_frame_cycles", n, 19);
    wait_idle();

    // Backpressure with snapshot isolation
    ready_pct = 50;
    start_frame(64'h0123_4567_89AB_CDEF, 64'h1, 1);
    wait_idle();

    // Extremes
    ready_pct = 100;
    start_frame('1, '1, 0);
    wait_idle();
    start_frame('0, '0, 0);
    wait_idle();

    // Overrun during byte 5
    ready_pct = 70;
    start_frame(64'hDEAD_BEEF_0000_1111, 64'h8000_0000_0000_0001, 0);
    wait_pos(5);
    @(posedge clk); #1 Req = 1'b1;
    @(posedge clk); #1 Req = 1'b0;
    wait_idle();
    check("overrun_set", Overrun, 1'b1);

    // Req in the Done cycle starts a new frame immediately
    ready_pct = 100;
    start_frame(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 0);
    n = 0;
    while (!Done && n < 100) begin
      @(negedge clk);
      n++;
    end
    Cnt0 = 64'hCAFE_F00D_1234_5678;
    Cnt1 = 64'h0F0F_F0F0_AAAA_5555;
    Req  = 1'b1;
    push_frame(Cnt0, Cnt1);
    @(posedge clk); #1 Req = 1'b0;
    @(negedge clk);
    check("done_cycle_req", {TxValid, TxData}, {1'b1, 8'hA5});
    wait_idle();
    check("overrun_sticky", Overrun, 1'b1);

    // Reset mid-frame, then a full fresh frame
    ready_pct = 60;
    start_frame(64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718, 1);
    wait_pos(10);
    scramble = 0;
    do_reset();
    start_frame(64'hA5A5_5A5A_FFFF_0000, 64'h0000_0000_0000_00FF, 0);
    wait_idle();

    // Random frames
    for (int f = 0; f < 8; f++) begin
      ready_pct = 20 + $urandom_range(80);
      start_frame({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(1)));
      wait_idle();
    end

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
